sample_source: RTL

SAMPLE_SOURCE -- requirements
Module: sample_source

---
 rtl/sample_source_pkg.sv | 25 ++
 rtl/sample_fifo.sv | 81 ++++++++
 rtl/sample_source.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sample_source_pkg.sv
// sample_source_pkg
// Shared definitions for the burst sample source: default burst length,
// default buffer depth and the state encodings of the ADC-side and
// output-side state machines.
package sample_source_pkg;

    localparam int DEF_NUM_SAMPLES = 1024;  // samples acquired per burst
    localparam int DEF_FIFO_DEPTH  = 4;     // internal buffer depth (power of two)

    // ADC-side handshake: soc out, eoc in.
    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_SOC   = 2'd1,
        A_WAIT0 = 2'd2,
        A_WAIT1 = 2'd3
    } adc_state_t;

    // Consumer-side handshake: dav_ out (active-low), rfd in.
    typedef enum logic [1:0] {
        O_IDLE  = 2'd0,
        O_WAIT0 = 2'd1,
        O_WAIT1 = 2'd2
    } out_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
// Small synchronous FIFO between the ADC side and the output side.
// The read data is registered: a pop loads the head entry into pop_data,
// which then holds until the next pop (or reset), so it can drive the
// downstream byte bus directly.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high; empties the FIFO, clears pop_data
//   push       : write push_data this cycle
//   push_data  : data to write
//   pop        : read the head entry into pop_data this cycle
//   pop_data   : registered head entry from the most recent pop
//   full/empty : occupancy flags
module sample_fifo
    import sample_source_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_pop_data;

    logic w_do_push;
    logic w_do_pop;

    assign full     = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign pop_data = r_pop_data;

    // A push while full is still legal when the same cycle pops: the slot
    // being read is freed at the same edge it would be overwritten.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pop_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_pop_data <= r_mem[r_rd_ptr];
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sample_source.sv
// sample_source
// Acquires a burst of NUM_SAMPLES bytes from an ADC (soc/eoc handshake) and
// hands them to a downstream consumer (dav_/rfd handshake). The two sides
// run as independent state machines that only meet at the FIFO, so a slow
// consumer back-pressures the ADC by stalling the next conversion start.
//
// Ports
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high; aborts everything, drops buffered data
//   start  : burst request, honoured only when idle and not busy
//   soc    : start-of-conversion to the ADC
//   eoc    : ADC end-of-conversion (0 converting, 1 result valid)
//   x7_x0  : ADC result
//   dav_   : data available, active-low
//   rfd    : consumer ready-for-data
//   d7_d0  : byte offered downstream
//   busy   : burst in progress
module sample_source
    import sample_source_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       soc,
    input  logic       eoc,
    input  logic [7:0] x7_x0,
    output logic       dav_,
    input  logic       rfd,
    output logic [7:0] d7_d0,
    output logic       busy
);

    localparam int CW = $clog2(NUM_SAMPLES + 1);

    adc_state_t r_adc_state, w_adc_next;
    out_state_t r_out_state, w_out_next;

    logic [CW-1:0] r_count, w_count_next;
    logic          r_soc, w_soc_next;
    logic          r_dav_n, w_dav_n_next;
    logic          r_busy, w_busy_next;
    logic          w_busy_set;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (x7_x0),
        .pop       (w_pop),
        .pop_data  (d7_d0),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign soc  = r_soc;
    assign dav_ = r_dav_n;
    assign busy = r_busy;

    // ADC side: one conversion per pass through A_SOC..A_WAIT1. A new
    // conversion is only started with room in the FIFO, which guarantees
    // the push in A_WAIT1 always has a free slot.
    always_comb begin
        w_adc_next   = r_adc_state;
        w_soc_next   = r_soc;
        w_count_next = r_count;
        w_push       = 1'b0;
        w_busy_set   = 1'b0;
        unique case (r_adc_state)
            A_IDLE: begin
                // busy stays high while the tail of a burst drains, so
                // start is ignored until the last byte has been taken.
                if (start && !r_busy) begin
                    w_count_next = CW'(NUM_SAMPLES);
                    w_busy_set   = 1'b1;
                    w_adc_next   = A_SOC;
                end
            end
            A_SOC: begin
                if (!w_full) begin
                    w_soc_next = 1'b1;
                    w_adc_next = A_WAIT0;
                end
            end
            A_WAIT0: begin
                if (!eoc) begin
                    w_soc_next = 1'b0;
                    w_adc_next = A_WAIT1;
                end
            end
            A_WAIT1: begin
                if (eoc) begin
                    w_push       = 1'b1;
                    w_count_next = r_count - CW'(1);
                    w_adc_next   = (r_count == CW'(1)) ? A_IDLE : A_SOC;
                end
            end
            default: w_adc_next = A_IDLE;
        endcase
    end

    // Output side: pop loads the registered FIFO output, which is the byte
    // bus, so d7_d0 is stable until the next pop, and a pop can only follow
    // a full dav_/rfd round trip.
    always_comb begin
        w_out_next   = r_out_state;
        w_dav_n_next = r_dav_n;
        w_pop        = 1'b0;
        unique case (r_out_state)
            O_IDLE: begin
                if (!w_empty && rfd) begin
                    w_pop        = 1'b1;
                    w_dav_n_next = 1'b0;
                    w_out_next   = O_WAIT0;
                end
            end
            O_WAIT0: begin
                if (!rfd) begin
                    w_dav_n_next = 1'b1;
                    w_out_next   = O_WAIT1;
                end
            end
            O_WAIT1: begin
                if (rfd) begin
                    w_out_next = O_IDLE;
                end
            end
            default: w_out_next = O_IDLE;
        endcase
    end

    // The burst is over when the final handshake closes with nothing left
    // in the FIFO and the ADC side already back in A_IDLE.
    always_comb begin
        w_busy_next = r_busy;
        if (r_out_state == O_WAIT1 && rfd && w_empty && r_adc_state == A_IDLE) begin
            w_busy_next = 1'b0;
        end
        if (w_busy_set) begin
            w_busy_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_adc_state <= A_IDLE;
            r_out_state <= O_IDLE;
            r_count     <= '0;
            r_soc       <= 1'b0;
            r_dav_n     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_adc_state <= w_adc_next;
            r_out_state <= w_out_next;
            r_count     <= w_count_next;
            r_soc       <= w_soc_next;
            r_dav_n     <= w_dav_n_next;
            r_busy      <= w_busy_next;
        end
    end

endmodule
